multicycle_control: RTL and testbench

Sequencing controller for the multi-cycle MIPS core, replacing the single-cycle combinational control path. It steps each instruction through fetch, decode, execute, memory and writeback states and stalls on ready handshakes from the instruction and data memories. It traps on illegal encodings or memory timeouts and counts retired instructions. It drives the existing PC, regfile, ALU, data memory and mux select lines each cycle.

---
 rtl/multicycle_control.sv | 237 +++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS sequencing controller with wait timeouts, traps and retire count
module multicycle_control #(
  parameter int CNT_WIDTH = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 alu_zero,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  output logic                 imem_read,
  output logic                 dmem_read,
  output logic                 dmem_write,
  output logic                 ir_load,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic [1:0]           pc_src,
  output logic                 alu_src_b,
  output logic [3:0]           alu_ctl,
  output logic [1:0]           reg_dst,
  output logic [1:0]           mem_to_reg,
  output logic [2:0]           state,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [CNT_WIDTH-1:0] retired
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  // Counter only needs to reach TIMEOUT; a disabled timeout keeps a 1-bit stub.
  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [2:0]        next_state;
  logic [1:0]        next_cause;
  logic              retire;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_expired;
  logic              waiting;

  // Instruction classes, valid while the datapath holds opcode/funct stable.
  logic is_rtype, is_ralu, is_jr, is_j, is_jal, is_beq, is_bne;
  logic is_addi, is_xori, is_lw, is_sw, is_legal;

  assign is_rtype = (opcode == 6'h00);
  assign is_ralu  = is_rtype && (funct == 6'h20 || funct == 6'h22 || funct == 6'h24 ||
                                 funct == 6'h25 || funct == 6'h2A);
  assign is_jr    = is_rtype && (funct == 6'h08);
  assign is_j     = (opcode == 6'h02);
  assign is_jal   = (opcode == 6'h03);
  assign is_beq   = (opcode == 6'h04);
  assign is_bne   = (opcode == 6'h05);
  assign is_addi  = (opcode == 6'h08);
  assign is_xori  = (opcode == 6'h0E);
  assign is_lw    = (opcode == 6'h23);
  assign is_sw    = (opcode == 6'h2B);
  assign is_legal = is_ralu | is_jr | is_j | is_jal | is_beq | is_bne |
                    is_addi | is_xori | is_lw | is_sw;

  // A ready arriving on the expiry cycle still wins, since ready is tested first below.
  assign wait_expired = (TIMEOUT != 0) && (wait_cnt == WAIT_W'(TIMEOUT));
  assign waiting      = ((state == S_FETCH) && !imem_ready) || ((state == S_MEM) && !dmem_ready);

  // Next-state selection, trap cause and retire event for the current cycle.
  always_comb begin
    next_state = state;
    next_cause = trap_cause;
    retire     = 1'b0;
    case (state)
      S_FETCH: begin
        if (imem_ready) begin
          next_state = S_DECODE;
        end else if (wait_expired) begin
          next_state = S_TRAP;
          next_cause = 2'b10;
        end
      end
      S_DECODE: begin
        if (is_legal) begin
          next_state = S_EXEC;
        end else begin
          next_state = S_TRAP;
          next_cause = 2'b01;
        end
      end
      S_EXEC: begin
        if (is_lw || is_sw) begin
          next_state = S_MEM;
        end else if (is_ralu || is_addi || is_xori) begin
          next_state = S_WB;
        end else begin
          next_state = S_FETCH;
          retire     = 1'b1;
        end
      end
      S_MEM: begin
        if (dmem_ready) begin
          if (is_sw) begin
            next_state = S_FETCH;
            retire     = 1'b1;
          end else begin
            next_state = S_WB;
          end
        end else if (wait_expired) begin
          next_state = S_TRAP;
          next_cause = 2'b11;
        end
      end
      S_WB: begin
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_TRAP:  next_state = S_TRAP;
      default: next_state = S_FETCH;
    endcase
  end

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Sticky trap flag and cause, only written on the transition into TRAP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trap       <= 1'b0;
      trap_cause <= 2'b00;
    end else if (next_state == S_TRAP) begin
      trap       <= 1'b1;
      trap_cause <= next_cause;
    end
  end

  // Retired-instruction count, wrapping naturally at its width.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired <= '0;
    end else if (retire) begin
      retired <= retired + CNT_WIDTH'(1);
    end
  end

  // Wait counter: zero on any state change, so every FETCH/MEM visit starts from 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (next_state != state) begin
      wait_cnt <= '0;
    end else if (waiting && (TIMEOUT != 0) && !wait_expired) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // Datapath control decode from state, instruction and ALU flag.
  always_comb begin
    imem_read  = 1'b0;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    ir_load    = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    pc_src     = 2'b00;
    alu_src_b  = 1'b0;
    alu_ctl    = 4'b0000;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    case (state)
      S_FETCH: begin
        imem_read = 1'b1;
        if (imem_ready) begin
          ir_load  = 1'b1;
          pc_write = 1'b1;
        end
      end
      S_EXEC: begin
        if (is_ralu) begin
          case (funct)
            6'h20:   alu_ctl = 4'b0010;
            6'h22:   alu_ctl = 4'b0110;
            6'h24:   alu_ctl = 4'b0000;
            6'h25:   alu_ctl = 4'b0001;
            6'h2A:   alu_ctl = 4'b0111;
            default: alu_ctl = 4'b0000;
          endcase
        end else if (is_addi || is_lw || is_sw) begin
          alu_ctl   = 4'b0010;
          alu_src_b = 1'b1;
        end else if (is_xori) begin
          alu_ctl   = 4'b1100;
          alu_src_b = 1'b1;
        end else if (is_beq || is_bne) begin
          alu_ctl = 4'b0110;
          if ((is_beq && alu_zero) || (is_bne && !alu_zero)) begin
            pc_write = 1'b1;
            pc_src   = 2'b01;
          end
        end else if (is_j || is_jal) begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
          if (is_jal) begin
            reg_write  = 1'b1;
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
          end
        end else if (is_jr) begin
          pc_write = 1'b1;
          pc_src   = 2'b11;
        end
      end
      S_MEM: begin
        dmem_read  = is_lw;
        dmem_write = is_sw;
      end
      S_WB: begin
        reg_write = 1'b1;
        if (is_ralu) begin
          reg_dst = 2'b01;
        end
        if (is_lw) begin
          mem_to_reg = 2'b01;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;

  localparam int CW = 4;
  localparam int TO = 4;
  localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4, T = 3'd5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [5:0]    opcode = 6'h00;
  logic [5:0]    funct = 6'h00;
  logic          alu_zero = 1'b0;
  logic          imem_ready = 1'b0;
  logic          dmem_ready = 1'b0;
  logic          imem_read, dmem_read, dmem_write, ir_load, pc_write, reg_write;
  logic [1:0]    pc_src;
  logic          alu_src_b;
  logic [3:0]    alu_ctl;
  logic [1:0]    reg_dst, mem_to_reg;
  logic [2:0]    state;
  logic          trap;
  logic [1:0]    trap_cause;
  logic [CW-1:0] retired;

  multicycle_control #(.CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_read(imem_read), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .ir_load(ir_load), .pc_write(pc_write), .reg_write(reg_write), .pc_src(pc_src),
    .alu_src_b(alu_src_b), .alu_ctl(alu_ctl), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .state(state), .trap(trap), .trap_cause(trap_cause), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef enum {K_ALU, K_ADDI, K_XORI, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_JR, K_BAD} kind_t;

  typedef struct {
    logic [2:0] st;
    logic       ir;
    logic       dr;
    logic [1:0] cause;
  } rec_t;

  typedef struct packed {
    logic       imem_read, dmem_read, dmem_write, ir_load, pc_write, reg_write;
    logic [1:0] pc_src;
    logic       alu_src_b;
    logic [3:0] alu_ctl;
    logic [1:0] reg_dst, mem_to_reg;
  } outs_t;

  int    n_checks = 0;
  int    n_pass = 0;
  rec_t  seq[$];
  rec_t  cur;
  kind_t cur_kind = K_ALU;
  logic  chk_en = 1'b0;
  int    model_ret = 0;
  int    n_dread = 0;
  int    n_fetch = 0;
  logic       ex_pcw, ex_rw;
  logic [1:0] ex_pcsrc, ex_rdst, ex_m2r, wb_rdst, wb_m2r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: begin
        if (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A) return K_ALU;
        if (fn == 6'h08) return K_JR;
        return K_BAD;
      end
      6'h02: return K_J;
      6'h03: return K_JAL;
      6'h04: return K_BEQ;
      6'h05: return K_BNE;
      6'h08: return K_ADDI;
      6'h0E: return K_XORI;
      6'h23: return K_LW;
      6'h2B: return K_SW;
      default: return K_BAD;
    endcase
  endfunction

  function automatic logic [3:0] rfn_alu(input logic [5:0] fn);
    case (fn)
      6'h20: return 4'b0010;
      6'h22: return 4'b0110;
      6'h24: return 4'b0000;
      6'h25: return 4'b0001;
      default: return 4'b0111;
    endcase
  endfunction

  // Expected control lines for one cycle, straight from the per-state action table.
  function automatic outs_t expect_out(input logic [2:0] st, input kind_t k, input logic [5:0] fn,
                                       input logic z, input logic ir);
    outs_t o;
    o = '0;
    if (st == F) begin
      o.imem_read = 1'b1;
      o.ir_load   = ir;
      o.pc_write  = ir;
    end else if (st == E) begin
      case (k)
        K_ALU: o.alu_ctl = rfn_alu(fn);
        K_ADDI, K_LW, K_SW: begin o.alu_ctl = 4'b0010; o.alu_src_b = 1'b1; end
        K_XORI: begin o.alu_ctl = 4'b1100; o.alu_src_b = 1'b1; end
        K_BEQ, K_BNE: begin
          o.alu_ctl = 4'b0110;
          if ((k == K_BEQ && z) || (k == K_BNE && !z)) begin o.pc_write = 1'b1; o.pc_src = 2'b01; end
        end
        K_J: begin o.pc_write = 1'b1; o.pc_src = 2'b10; end
        K_JAL: begin
          o.pc_write = 1'b1; o.pc_src = 2'b10;
          o.reg_write = 1'b1; o.reg_dst = 2'b10; o.mem_to_reg = 2'b10;
        end
        K_JR: begin o.pc_write = 1'b1; o.pc_src = 2'b11; end
        default: ;
      endcase
    end else if (st == M) begin
      o.dmem_read  = (k == K_LW);
      o.dmem_write = (k == K_SW);
    end else if (st == W) begin
      o.reg_write = 1'b1;
      if (k == K_ALU) o.reg_dst = 2'b01;
      if (k == K_LW) o.mem_to_reg = 2'b01;
    end
    return o;
  endfunction

  function automatic void push(input logic [2:0] st, input logic ir, input logic dr, input logic [1:0] c);
    rec_t r;
    r.st = st; r.ir = ir; r.dr = dr; r.cause = c;
    seq.push_back(r);
  endfunction

  // Cycle-by-cycle state sequence of one instruction given its wait schedule.
  function automatic void build(input kind_t k, input int iw, input int dw);
    seq.delete();
    if (iw > TO) begin
      for (int i = 0; i <= TO; i++) push(F, 1'b0, 1'b0, 2'b00);
      for (int i = 0; i < 4; i++) push(T, 1'b0, 1'b0, 2'b10);
      return;
    end
    for (int i = 0; i < iw; i++) push(F, 1'b0, 1'b0, 2'b00);
    push(F, 1'b1, 1'b0, 2'b00);
    push(D, 1'b0, 1'b0, 2'b00);
    if (k == K_BAD) begin
      for (int i = 0; i < 4; i++) push(T, 1'b0, 1'b0, 2'b01);
      return;
    end
    push(E, 1'b0, 1'b0, 2'b00);
    if (k == K_LW || k == K_SW) begin
      if (dw > TO) begin
        for (int i = 0; i <= TO; i++) push(M, 1'b0, 1'b0, 2'b00);
        for (int i = 0; i < 4; i++) push(T, 1'b0, 1'b0, 2'b11);
        return;
      end
      for (int i = 0; i < dw; i++) push(M, 1'b0, 1'b0, 2'b00);
      push(M, 1'b0, 1'b1, 2'b00);
    end
    if (k == K_ALU || k == K_ADDI || k == K_XORI || k == K_LW) push(W, 1'b0, 1'b0, 2'b00);
  endfunction

  // Plays the first n records; entered and left just after a rising edge.
  task automatic play(input logic [5:0] op, input logic [5:0] fn, input logic z, input int n);
    opcode = op; funct = fn; alu_zero = z; cur_kind = classify(op, fn);
    chk_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      cur = seq[i];
      imem_ready = cur.ir;
      dmem_ready = cur.dr;
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    chk_en = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z, input int iw, input int dw);
    build(classify(op, fn), iw, dw);
    play(op, fn, z, seq.size());
    if (seq[seq.size()-1].st != T) model_ret++;
  endtask

  task automatic hold_trap(input logic [1:0] c);
    seq.delete();
    for (int i = 0; i < 20; i++) push(T, i[0], ~i[0], c);
    play(opcode, funct, alu_zero, 20);
  endtask

  task automatic do_reset();
    #1 reset = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'(F));
    chk("rst_imem_read", 32'(imem_read), 32'd1);
    chk("rst_dmem_write", 32'(dmem_write), 32'd0);
    chk("rst_dmem_read", 32'(dmem_read), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_trap", 32'(trap), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    model_ret = 0;
  endtask

  // Compare process: every modelled cycle, all outputs against the model.
  always @(negedge clk) begin
    outs_t e;
    logic [CW-1:0] r;
    if (chk_en) begin
      e = expect_out(cur.st, cur_kind, funct, alu_zero, cur.ir);
      r = model_ret[CW-1:0];
      chk("state", 32'(state), 32'(cur.st));
      chk("imem_read", 32'(imem_read), 32'(e.imem_read));
      chk("dmem_read", 32'(dmem_read), 32'(e.dmem_read));
      chk("dmem_write", 32'(dmem_write), 32'(e.dmem_write));
      chk("ir_load", 32'(ir_load), 32'(e.ir_load));
      chk("pc_write", 32'(pc_write), 32'(e.pc_write));
      chk("reg_write", 32'(reg_write), 32'(e.reg_write));
      chk("pc_src", 32'(pc_src), 32'(e.pc_src));
      chk("alu_src_b", 32'(alu_src_b), 32'(e.alu_src_b));
      chk("alu_ctl", 32'(alu_ctl), 32'(e.alu_ctl));
      chk("reg_dst", 32'(reg_dst), 32'(e.reg_dst));
      chk("mem_to_reg", 32'(mem_to_reg), 32'(e.mem_to_reg));
      chk("trap", 32'(trap), 32'(cur.st == T));
      chk("trap_cause", 32'(trap_cause), 32'(cur.cause));
      chk("retired", 32'(retired), 32'(r));
      if (dmem_read) n_dread++;
      if (state == F) n_fetch++;
      if (state == E) begin
        ex_pcw = pc_write; ex_pcsrc = pc_src; ex_rw = reg_write; ex_rdst = reg_dst; ex_m2r = mem_to_reg;
      end
      if (state == W) begin
        wb_rdst = reg_dst; wb_m2r = mem_to_reg;
      end
    end
  end

  logic [5:0] wop [8] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0E, 6'h2B};
  logic [5:0] wfn [8] = '{6'h25, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("init_state", 32'(state), 32'd0);
    chk("init_imem_read", 32'(imem_read), 32'd1);
    chk("init_pc_write", 32'(pc_write), 32'd0);
    chk("init_retired", 32'(retired), 32'd0);
    chk("init_trap_cause", 32'(trap_cause), 32'd0);
    reset = 1'b1;

    // add, zero-wait: F D E W, four cycles
    build(classify(6'h00, 6'h20), 0, 0);
    chk("add_len", 32'(seq.size()), 32'd4);
    run(6'h00, 6'h20, 1'b0, 0, 0);
    chk("add_retired", 32'(retired), 32'd1);
    chk("add_wb_reg_dst", 32'(wb_rdst), 32'd1);

    // lw with three dmem waits: eight cycles, four of dmem_read
    n_dread = 0;
    build(classify(6'h23, 6'h00), 0, 3);
    chk("lw_len", 32'(seq.size()), 32'd8);
    run(6'h23, 6'h00, 1'b0, 0, 3);
    chk("lw_dread_cycles", 32'(n_dread), 32'd4);
    chk("lw_wb_m2r", 32'(wb_m2r), 32'd1);
    chk("lw_retired", 32'(retired), 32'd2);

    run(6'h04, 6'h00, 1'b1, 0, 0);
    chk("beq_pc_write", 32'(ex_pcw), 32'd1);
    chk("beq_pc_src", 32'(ex_pcsrc), 32'd1);
    run(6'h05, 6'h00, 1'b1, 0, 0);
    chk("bne_pc_write", 32'(ex_pcw), 32'd0);
    run(6'h04, 6'h00, 1'b0, 1, 0);
    run(6'h05, 6'h00, 1'b0, 0, 0);
    chk("branch_retired", 32'(retired), 32'd6);

    run(6'h03, 6'h00, 1'b0, 0, 0);
    chk("jal_pc_write", 32'(ex_pcw), 32'd1);
    chk("jal_pc_src", 32'(ex_pcsrc), 32'd2);
    chk("jal_reg_write", 32'(ex_rw), 32'd1);
    chk("jal_reg_dst", 32'(ex_rdst), 32'd2);
    chk("jal_m2r", 32'(ex_m2r), 32'd2);

    run(6'h02, 6'h00, 1'b0, 2, 0);
    run(6'h00, 6'h08, 1'b0, 0, 0);
    run(6'h00, 6'h22, 1'b0, 1, 0);
    run(6'h00, 6'h24, 1'b1, 0, 0);
    run(6'h00, 6'h2A, 1'b0, 3, 0);
    run(6'h08, 6'h00, 1'b0, 0, 0);
    run(6'h0E, 6'h00, 1'b0, 0, 0);
    // ready on the expiry cycle wins over the timeout
    run(6'h2B, 6'h00, 1'b0, TO, TO);
    run(6'h23, 6'h00, 1'b0, 0, TO);

    // illegal opcode
    run(6'h3F, 6'h00, 1'b0, 0, 0);
    chk("ill_state", 32'(state), 32'd5);
    chk("ill_cause", 32'(trap_cause), 32'd1);
    hold_trap(2'b01);
    do_reset();

    // unlisted funct under R-type
    run(6'h00, 6'h21, 1'b0, 0, 0);
    chk("illf_cause", 32'(trap_cause), 32'd1);
    do_reset();

    // imem timeout: trap decided on the fifth FETCH cycle
    n_fetch = 0;
    run(6'h00, 6'h20, 1'b0, 100, 0);
    chk("ito_fetch_cycles", 32'(n_fetch), 32'd5);
    chk("ito_cause", 32'(trap_cause), 32'd2);
    hold_trap(2'b10);
    chk("ito_still_trap", 32'(state), 32'd5);
    do_reset();

    // dmem timeout
    run(6'h23, 6'h00, 1'b0, 0, 100);
    chk("dto_cause", 32'(trap_cause), 32'd3);
    do_reset();

    // 17 retirements on a 4-bit counter wrap to 1
    for (int i = 0; i < 17; i++) run(wop[i % 8], wfn[i % 8], i[0], i % 3, i % 2);
    chk("wrap_retired", 32'(retired), 32'd1);

    // reset while sw waits in MEM drops the strobe and clears the count
    build(K_SW, 0, 3);
    play(6'h2B, 6'h00, 1'b0, 4);
    chk("sw_wait_dwrite", 32'(dmem_write), 32'd1);
    do_reset();
    run(6'h00, 6'h20, 1'b0, 0, 0);
    chk("post_reset_retired", 32'(retired), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1);
  end

endmodule
